mips_mem_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory between the IF stage (fetch, read-only) and the MEM stage (LW/SW).

---
 rtl/mips_mem_arb_pkg.sv | 20 ++
 rtl/mips_arb_starve_ctr.sv | 35 +++
 rtl/mips_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the unified-memory IF/MEM arbiter.
package mips_mem_arb_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int unsigned STAT_W = 16;

    // Saturating +1 for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mips_arb_starve_ctr.sv
// Saturating up-counter with clear; at_max_o flags that the limit has been reached.
module mips_arb_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == CW'(MAX));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the single-port unified memory between fetch and data, returning read data to its issuer.
// Optional statistics counters are built when MIPS_MEM_ARB_STATS_EN is defined.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              stall_if,
    output logic [STAT_W-1:0] stat_conflicts,
    output logic [STAT_W-1:0] stat_forced
);

    rsp_state_e rsp_q, rsp_d;
    logic       starve_max;
    logic       force_if;
    logic       gnt_port;

    // Data has priority unless fetch has been denied STARVE_MAX cycles in a row.
    assign force_if = rst_n && if_req && starve_max;
    assign d_gnt    = rst_n && d_req && !force_if;
    assign if_gnt   = rst_n && if_req && !d_gnt;
    assign stall_if = rst_n && if_req && !if_gnt;
    assign gnt_port = d_gnt ? PORT_D : PORT_IF;

    mips_arb_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk1),
        .rst_n    (rst_n),
        .inc_i    (if_req && !if_gnt),
        .clr_i    (if_gnt || !if_req),
        .at_max_o (starve_max)
    );

    // Memory request mux from whichever port holds the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt || if_gnt) begin
            mem_en = 1'b1;
            if (gnt_port == PORT_D) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end else begin
                mem_addr = if_addr;
            end
        end
    end

    // Response owner: who receives mem_rdata in the next cycle.
    always_comb begin
        rsp_d = RSP_NONE;
        if (if_gnt) begin
            rsp_d = RSP_IF;
        end else if (d_gnt && !d_we) begin
            rsp_d = RSP_D;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q <= RSP_NONE;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    assign if_rvalid = (rsp_q == RSP_IF);
    assign d_rvalid  = (rsp_q == RSP_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;

`ifdef MIPS_MEM_ARB_STATS_EN
    logic [STAT_W-1:0] conflicts_q;
    logic [STAT_W-1:0] forced_q;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            conflicts_q <= '0;
            forced_q    <= '0;
        end else begin
            if (if_req && d_req) begin
                conflicts_q <= sat_inc(conflicts_q);
            end
            if (force_if) begin
                forced_q <= sat_inc(forced_q);
            end
        end
    end

    assign stat_conflicts = conflicts_q;
    assign stat_forced    = forced_q;
`else
    assign stat_conflicts = '0;
    assign stat_forced    = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mips_mem_arbiter;

    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;
    localparam int unsigned MEMN = 1 << AW;
`ifdef MIPS_MEM_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic          clk1, rst_n;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          stall_if;
    logic [15:0]   stat_conflicts, stat_forced;

    int tests_run;
    int tests_failed;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_if(stall_if),
        .stat_conflicts(stat_conflicts), .stat_forced(stat_forced)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Memory: request captured at negedge (inputs are stable then), acted on at posedge.
    logic [DW-1:0] mem [MEMN];
    logic          l_en, l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;

    always @(negedge clk1) begin
        l_en    <= mem_en;
        l_we    <= mem_we;
        l_addr  <= mem_addr;
        l_wdata <= mem_wdata;
    end

    always @(posedge clk1) begin
        if (l_en && l_we) mem[l_addr] <= l_wdata;
        if (l_en && !l_we) mem_rdata <= mem[l_addr];
        else               mem_rdata <= $urandom;
    end

    // Reference model: who may use memory this cycle, and what each port sees next.
    logic [DW-1:0] ref_mem [MEMN];
    int            m_wait;
    int            m_owner;
    logic [DW-1:0] m_data;
    int            m_conf, m_forced;

    logic          e_if_gnt, e_d_gnt, e_stall, e_en, e_we, e_force;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_if_rv, e_d_rv;
    logic [DW-1:0] e_if_rd, e_d_rd;
    logic [15:0]   e_conf, e_forced;

    task automatic model_eval();
        e_force  = rst_n && if_req && (m_wait >= int'(SMAX));
        e_d_gnt  = rst_n && d_req && !e_force;
        e_if_gnt = rst_n && if_req && !e_d_gnt;
        e_stall  = rst_n && if_req && !e_if_gnt;
        e_en     = e_d_gnt || e_if_gnt;
        e_we     = e_d_gnt && d_we;
        e_addr   = e_d_gnt ? d_addr : (e_if_gnt ? if_addr : '0);
        e_wdata  = d_wdata;
        e_if_rv  = rst_n && (m_owner == 1);
        e_d_rv   = rst_n && (m_owner == 2);
        e_if_rd  = e_if_rv ? m_data : '0;
        e_d_rd   = e_d_rv ? m_data : '0;
        e_conf   = STATS_ON ? 16'(m_conf) : 16'd0;
        e_forced = STATS_ON ? 16'(m_forced) : 16'd0;
    endtask

    task automatic model_commit();
        model_eval();
        if (!rst_n) begin
            m_wait = 0; m_owner = 0; m_data = '0; m_conf = 0; m_forced = 0;
        end else begin
            m_owner = 0;
            if (e_if_gnt) begin
                m_owner = 1; m_data = ref_mem[if_addr];
            end else if (e_d_gnt && !d_we) begin
                m_owner = 2; m_data = ref_mem[d_addr];
            end else if (e_d_gnt) begin
                ref_mem[d_addr] = d_wdata;
            end
            if (if_req && !e_if_gnt) m_wait = (m_wait < int'(SMAX)) ? m_wait + 1 : m_wait;
            else                     m_wait = 0;
            if (if_req && d_req && m_conf < 65535) m_conf++;
            if (e_force && m_forced < 65535) m_forced++;
        end
    endtask

    task automatic settle();
        @(negedge clk1);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk1);
        model_commit();
        #1;
    endtask

    task automatic idle();
        if_req = 0; d_req = 0; d_we = 0;
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic test_reset();
        rst_n = 0; if_req = 1; d_req = 1; d_we = 0; if_addr = 10'd1; d_addr = 10'd2;
        #3;
        tests_run++;
        if ({if_gnt, d_gnt, mem_en, stall_if, if_rvalid, d_rvalid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b exp 000000", {if_gnt, d_gnt, mem_en, stall_if, if_rvalid, d_rvalid});
        end
        tests_run++;
        if ({mem_addr, if_rdata, d_rdata, stat_conflicts, stat_forced} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data got addr=%0h ird=%0h drd=%0h sc=%0d sf=%0d exp all 0",
                     mem_addr, if_rdata, d_rdata, stat_conflicts, stat_forced);
        end
        idle();
        advance();
        advance();
        rst_n = 1;
        advance();
    endtask

    task automatic test_fetch_only();
        poke(10'd5, 32'hDEAD_BEEF);
        if_req = 1; if_addr = 10'd5;
        settle();
        tests_run++;
        if ({if_gnt, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 10'd5}) begin
            tests_failed++;
            $display("FAIL fetch_gnt got gnt=%b en=%b we=%b addr=%0d exp 1 1 0 5", if_gnt, mem_en, mem_we, mem_addr);
        end
        advance();
        if_req = 0;
        settle();
        tests_run++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL fetch_rdata got v=%b d=%h exp 1 deadbeef", if_rvalid, if_rdata);
        end
        advance();
    endtask

    task automatic test_conflict();
        poke(10'd9, 32'h0BAD_F00D);
        poke(10'd20, 32'h2000_0014);
        d_req = 1; d_we = 0; d_addr = 10'd9; if_req = 1; if_addr = 10'd20;
        settle();
        tests_run++;
        if ({d_gnt, if_gnt, stall_if} !== 3'b101) begin
            tests_failed++;
            $display("FAIL conflict_gnt got d=%b if=%b stall=%b exp 1 0 1", d_gnt, if_gnt, stall_if);
        end
        advance();
        d_req = 0;
        settle();
        tests_run++;
        if ({d_rvalid, if_rvalid, d_rdata, if_gnt} !== {1'b1, 1'b0, 32'h0BAD_F00D, 1'b1}) begin
            tests_failed++;
            $display("FAIL conflict_resp got drv=%b irv=%b drd=%h ignt=%b exp 1 0 0badf00d 1",
                     d_rvalid, if_rvalid, d_rdata, if_gnt);
        end
        advance();
        if_req = 0;
        settle();
        tests_run++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h2000_0014}) begin
            tests_failed++;
            $display("FAIL conflict_fetch got v=%b d=%h exp 1 20000014", if_rvalid, if_rdata);
        end
        advance();
    endtask

    task automatic test_starvation();
        int f0;
        f0 = m_forced;
        d_req = 1; d_we = 1; d_addr = 10'd100; d_wdata = 32'h5555_0000; if_req = 1; if_addr = 10'd40;
        for (int c = 0; c < 6; c++) begin
            settle();
            tests_run++;
            if ({d_gnt, if_gnt} !== ((c == 4) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL starve_c%0d got d=%b if=%b exp %b", c, d_gnt, if_gnt, (c == 4) ? 2'b01 : 2'b10);
            end
            advance();
        end
        idle();
        settle();
        tests_run++;
        if (stat_forced !== (STATS_ON ? 16'(f0 + 1) : 16'd0)) begin
            tests_failed++;
            $display("FAIL starve_stat got %0d exp %0d", stat_forced, STATS_ON ? f0 + 1 : 0);
        end
        advance();
    endtask

    task automatic test_store_load();
        d_req = 1; d_we = 1; d_addr = 10'd3; d_wdata = 32'h0000_1234;
        settle();
        tests_run++;
        if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 10'd3, 32'h1234}) begin
            tests_failed++;
            $display("FAIL store_req got g=%b en=%b we=%b a=%0d wd=%h exp 1 1 1 3 1234",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        advance();
        d_we = 0;
        settle();
        tests_run++;
        if ({d_rvalid, d_gnt, mem_we} !== 3'b010) begin
            tests_failed++;
            $display("FAIL store_norv got rv=%b g=%b we=%b exp 0 1 0", d_rvalid, d_gnt, mem_we);
        end
        advance();
        d_req = 0;
        settle();
        tests_run++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h1234}) begin
            tests_failed++;
            $display("FAIL load_back got v=%b d=%h exp 1 1234", d_rvalid, d_rdata);
        end
        advance();
    endtask

    task automatic test_reset_inflight();
        int n;
        bit got;
        d_req = 1; d_we = 0; d_addr = 10'd7;
        settle();
        advance();
        rst_n = 0;
        #1;
        tests_run++;
        if ({d_rvalid, d_rdata, d_gnt, mem_en} !== '0) begin
            tests_failed++;
            $display("FAIL rst_inflight got rv=%b rd=%h g=%b en=%b exp 0 0 0 0", d_rvalid, d_rdata, d_gnt, mem_en);
        end
        idle();
        advance();
        rst_n = 1;
        settle();
        tests_run++;
        if ({d_rvalid, if_rvalid, stat_conflicts, stat_forced} !== '0) begin
            tests_failed++;
            $display("FAIL rst_release got drv=%b irv=%b sc=%0d sf=%0d exp 0", d_rvalid, if_rvalid, stat_conflicts, stat_forced);
        end
        advance();
        d_req = 1; d_we = 1; d_addr = 10'd200; d_wdata = 32'h7777_7777; if_req = 1; if_addr = 10'd50;
        n = 0; got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            settle();
            if (if_gnt) got = 1;
            else if (d_gnt) n++;
            advance();
        end
        tests_run++;
        if (!got || n != int'(SMAX)) begin
            tests_failed++;
            $display("FAIL rst_starve_clear got granted=%0d data_wins=%0d exp 1 %0d", got, n, SMAX);
        end
        idle();
        advance();
    endtask

    task automatic test_stats();
        rst_n = 0;
        #1;
        advance();
        rst_n = 1;
        advance();
        for (int c = 0; c < 3; c++) begin
            d_req = 1; d_we = 0; d_addr = 10'(c); if_req = 1; if_addr = 10'd60;
            settle();
            advance();
        end
        idle();
        settle();
        tests_run++;
        if (stat_conflicts !== (STATS_ON ? 16'd3 : 16'd0)) begin
            tests_failed++;
            $display("FAIL stat_conflicts got %0d exp %0d", stat_conflicts, STATS_ON ? 3 : 0);
        end
        advance();
    endtask

    task automatic test_random();
        int  bad;
        bit  g_if, g_d;
        bad = 0;
        idle();
        for (int c = 0; c < 400; c++) begin
            settle();
            tests_run++;
            if ({if_gnt, d_gnt, stall_if, mem_en, mem_we} !== {e_if_gnt, e_d_gnt, e_stall, e_en, e_we}
                || mem_addr !== e_addr || (e_we && mem_wdata !== e_wdata)) begin
                tests_failed++;
                $display("FAIL rand_req c%0d got %b a=%0d exp %b a=%0d", c,
                         {if_gnt, d_gnt, stall_if, mem_en, mem_we}, mem_addr,
                         {e_if_gnt, e_d_gnt, e_stall, e_en, e_we}, e_addr);
            end
            tests_run++;
            if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== {e_if_rv, e_d_rv, e_if_rd, e_d_rd}) begin
                tests_failed++;
                $display("FAIL rand_rsp c%0d got %b%b %h %h exp %b%b %h %h", c, if_rvalid, d_rvalid,
                         if_rdata, d_rdata, e_if_rv, e_d_rv, e_if_rd, e_d_rd);
            end
            tests_run++;
            if ({stat_conflicts, stat_forced} !== {e_conf, e_forced}) begin
                tests_failed++;
                $display("FAIL rand_stat c%0d got %0d %0d exp %0d %0d", c, stat_conflicts, stat_forced, e_conf, e_forced);
            end
            g_if = e_if_gnt;
            g_d  = e_d_gnt;
            advance();
            if (!if_req || g_if) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 10'($urandom_range(0, 15));
            end
            if (!d_req || g_d) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) != 0;
                d_addr  = 10'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
        end
        idle();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] v;
        tests_run = 0; tests_failed = 0;
        m_wait = 0; m_owner = 0; m_data = '0; m_conf = 0; m_forced = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < int'(MEMN); i++) begin
            v = $urandom;
            poke(10'(i), v);
        end
        test_reset();
        test_fetch_only();
        test_conflict();
        test_starvation();
        test_store_load();
        test_reset_inflight();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
